cmn_trace_buffer: RTL and testbench
===================================

# cmn_trace_buffer

Synthesizable, parametrised trace capture block for val/rdy interfaces. It monitors NCHAN handshake channels and timestamps every cycle in which any channel's val/rdy pair changes. Each such event goes into a DEPTH-entry circular buffer, which software or a bench drains through a val/rdy read port. It is the hardware counterpart of the simulation-only line-trace facility: it records the same val/rdy states and cycle count on silicon or FPGA, where `$write` is unavailable.

## Interface

Parameters:
- NCHAN, 4: number of monitored val/rdy channels (1..16).
- DEPTH, 16: buffer entries; power of two, ≥2.
- TS_BITS, 16: timestamp and cycle-counter width.
- MODE, 0: full-buffer policy. 0 = wrap (overwrite oldest); 1 = stop (drop newest).

Ports (W = TS_BITS + 2*NCHAN):
- clk, in, 1: sole clock; all state updates on posedge.
- reset, in, 1: synchronous, active-low (0 = reset).
- en, in, 1: capture enable (level).
- clear, in, 1: synchronous active-high flush of buffer, flags and counter.
- mon_val, in, NCHAN: monitored val bits.
- mon_rdy, in, NCHAN: monitored rdy bits.
- rd_val, out, 1: an entry is available.
- rd_rdy, in, 1: consumer ready.
- rd_msg, out, W: {timestamp, mon_val, mon_rdy} of the oldest entry. Timestamp is in the MSBs and mon_rdy in the LSBs.
- count, out, $clog2(DEPTH)+1: current occupancy.
- full, out, 1: count == DEPTH.
- overflow, out, 1: sticky; set when an event is lost or overwritten.
- cycles, out, TS_BITS: free-running cycle counter.

## Operation

- Reset (reset==0) and clear (clear==1) have identical effect and take priority over all other activity:
  - count, wr_ptr, rd_ptr, cycles and overflow go to 0.
  - prev_valid goes to 0.
- cycles increments by 1 every non-reset/non-clear cycle, independent of en. It wraps 2^TS_BITS-1 → 0.
- Sample vector S = {mon_val, mon_rdy}.
- Event in cycle t: en==1 && (!prev_valid || S != prev_S).
  - When en==1, prev_S <= S and prev_valid <= 1.
  - When en==0, prev_valid <= 0, so the first enabled cycle after re-enable always records.
- An event writes {cycles(t), S} into mem[wr_ptr].
- Pop: rd_val && rd_rdy. rd_ptr advances and count decrements.
- Write acceptance:
  - count < DEPTH: write, wr_ptr++, count++ (net 0 with simultaneous pop).
  - count == DEPTH with pop same cycle: write accepted, count stays DEPTH, overflow unchanged.
  - count == DEPTH, no pop, MODE 0: overwrite oldest. Write at wr_ptr, advance both pointers, count stays DEPTH, overflow <= 1.
  - count == DEPTH, no pop, MODE 1: event dropped, state unchanged, overflow <= 1.
- Pointers are log2(DEPTH) bits and wrap naturally.
- rd_val = (count != 0).
- rd_msg = rd_val ? mem[rd_ptr] : 0. This is a combinational read of the register array.
- overflow clears only on reset or clear.
- X on mon_val/mon_rdy is not supported; the bench must drive known values.

## Timing

- Reset values: rd_val=0, rd_msg=0, count=0, full=0, overflow=0, cycles=0.
- Event in cycle t: entry is visible (rd_val, rd_msg, count) in cycle t+1.
- Pop in cycle t: next entry is presented in cycle t+1.
- The read port sustains 1 pop/cycle; the write port sustains 1 event/cycle. These can occur in the same cycle.
- rd_msg is stable while rd_val==1 and rd_rdy==0, except in MODE 0 overwrite-when-full. In that case the head advances to the next-oldest entry.
- Reset or clear asserted mid-drain: rd_val falls the next cycle. A concurrent pop or event in that cycle is discarded.
- cycles(t) recorded is the counter value before that cycle's increment.

## Test plan

- **Reset:** hold reset=0 for 3 cycles with mon activity and en=1 → all outputs 0. Release; the first enabled cycle records an entry with ts=0 and rd_val=1 next cycle.
- **Change compression:** NCHAN=4, en=1. Drive S constant for 5 cycles, then flip mon_val[2] at cycle 6 → exactly 2 entries with ts 0 and 6. Second rd_msg = {16'd6, 4'b0100, rdy}.
- **Wrap mode:** DEPTH=4, MODE=0, rd_rdy=0, 6 events at ts 0..5 → count=4, full=1, overflow=1. Drain yields ts 2,3,4,5.
- **Stop mode:** same stimulus with MODE=1 → drain yields ts 0,1,2,3 and overflow=1.
- **Full with simultaneous pop:** DEPTH=4 full, event and pop in the same cycle → count stays 4, overflow stays 0, ordering preserved.
- **Clear and timestamp wrap:**
  - TS_BITS=4: an event at cycle 17 is recorded with ts=1.
  - clear=1 while count=3 → next cycle count=0, overflow=0, cycles=0; the next enabled cycle records with ts 0.

Source files
------------

// File: rtl/cmn_trace_buffer.sv
// Trace capture for NCHAN val/rdy channels: every cycle where the sampled handshake
// vector changes is timestamped and stored in a circular buffer drained through a val/rdy port.
module cmn_trace_buffer #(
    parameter int NCHAN   = 4,
    parameter int DEPTH   = 16,
    parameter int TS_BITS = 16,
    parameter int MODE    = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          en_i,
    input  logic                          clear_i,
    input  logic [NCHAN-1:0]              mon_val_i,
    input  logic [NCHAN-1:0]              mon_rdy_i,
    output logic                          rd_val_o,
    input  logic                          rd_rdy_i,
    output logic [TS_BITS+2*NCHAN-1:0]    rd_msg_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          full_o,
    output logic                          overflow_o,
    output logic [TS_BITS-1:0]            cycles_o
);

    localparam int W  = TS_BITS + 2*NCHAN;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]         mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [TS_BITS-1:0]   cycles_q, cycles_d;
    logic                 overflow_q, overflow_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [2*NCHAN-1:0]   prev_s_q, prev_s_d;

    logic [2*NCHAN-1:0]   sample;
    logic                 is_full;
    logic                 is_event;
    logic                 do_pop;
    logic                 do_write;
    logic                 do_overwrite;
    logic                 lose;

    assign sample = {mon_val_i, mon_rdy_i};

    // A full buffer loses an event only when no pop frees a slot in the same cycle.
    always_comb begin
        is_full      = (count_q == FULL_CNT);
        is_event     = en_i && (!prev_valid_q || (sample != prev_s_q));
        do_pop       = (count_q != '0) && rd_rdy_i;
        lose         = is_event && is_full && !do_pop;
        do_write     = is_event && (!lose || (MODE == 0));
        do_overwrite = lose && (MODE == 0);

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cycles_d     = cycles_q + TS_BITS'(1);
        overflow_d   = overflow_q | lose;
        prev_valid_d = en_i;
        prev_s_d     = en_i ? sample : prev_s_q;

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop || do_overwrite) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_write && !do_pop && !is_full) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_write) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni || clear_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cycles_q     <= '0;
            overflow_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_s_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cycles_q     <= cycles_d;
            overflow_q   <= overflow_d;
            prev_valid_q <= prev_valid_d;
            prev_s_q     <= prev_s_d;
        end
    end

    // Storage carries no reset; entries are only observable through count_q.
    always_ff @(posedge clk_i) begin
        if (reset_ni && !clear_i && do_write) begin
            mem_q[wr_ptr_q] <= {cycles_q, sample};
        end
    end

    assign rd_val_o   = (count_q != '0);
    assign rd_msg_o   = rd_val_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;
    assign full_o     = is_full;
    assign overflow_o = overflow_q;
    assign cycles_o   = cycles_q;

endmodule

// File: tb/tb_cmn_trace_buffer.sv
// Directed bench for cmn_trace_buffer: reset, change compression, wrap/stop policies,
// full-with-pop, clear and timestamp wrap, using four differently parameterised instances.
module tb_cmn_trace_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Default instance: 4 channels, 16 entries, 16-bit timestamps, wrap mode.
    logic        a_reset, a_en, a_clear, a_rd_rdy, a_rd_val, a_full, a_ovf;
    logic [3:0]  a_val, a_rdy;
    logic [23:0] a_rd_msg;
    logic [4:0]  a_count;
    logic [15:0] a_cycles;

    // Wrap and stop instances share all inputs.
    logic        w_reset, w_en, w_clear, w_rd_rdy;
    logic [3:0]  w_val, w_rdy;
    logic        w_rd_val, w_full, w_ovf, s_rd_val, s_full, s_ovf;
    logic [23:0] w_rd_msg, s_rd_msg;
    logic [2:0]  w_count, s_count;
    logic [15:0] w_cycles, s_cycles;

    // Narrow timestamp instance.
    logic        t_reset, t_en, t_clear, t_rd_rdy, t_rd_val, t_full, t_ovf;
    logic [3:0]  t_val, t_rdy, t_cycles;
    logic [11:0] t_rd_msg;
    logic [4:0]  t_count;

    cmn_trace_buffer #(.NCHAN(4), .DEPTH(16), .TS_BITS(16), .MODE(0)) dutA (
        .clk_i(clk), .reset_ni(a_reset), .en_i(a_en), .clear_i(a_clear),
        .mon_val_i(a_val), .mon_rdy_i(a_rdy), .rd_val_o(a_rd_val), .rd_rdy_i(a_rd_rdy),
        .rd_msg_o(a_rd_msg), .count_o(a_count), .full_o(a_full), .overflow_o(a_ovf),
        .cycles_o(a_cycles));

    cmn_trace_buffer #(.NCHAN(4), .DEPTH(4), .TS_BITS(16), .MODE(0)) dutW (
        .clk_i(clk), .reset_ni(w_reset), .en_i(w_en), .clear_i(w_clear),
        .mon_val_i(w_val), .mon_rdy_i(w_rdy), .rd_val_o(w_rd_val), .rd_rdy_i(w_rd_rdy),
        .rd_msg_o(w_rd_msg), .count_o(w_count), .full_o(w_full), .overflow_o(w_ovf),
        .cycles_o(w_cycles));

    cmn_trace_buffer #(.NCHAN(4), .DEPTH(4), .TS_BITS(16), .MODE(1)) dutS (
        .clk_i(clk), .reset_ni(w_reset), .en_i(w_en), .clear_i(w_clear),
        .mon_val_i(w_val), .mon_rdy_i(w_rdy), .rd_val_o(s_rd_val), .rd_rdy_i(w_rd_rdy),
        .rd_msg_o(s_rd_msg), .count_o(s_count), .full_o(s_full), .overflow_o(s_ovf),
        .cycles_o(s_cycles));

    cmn_trace_buffer #(.NCHAN(4), .DEPTH(16), .TS_BITS(4), .MODE(0)) dutT (
        .clk_i(clk), .reset_ni(t_reset), .en_i(t_en), .clear_i(t_clear),
        .mon_val_i(t_val), .mon_rdy_i(t_rdy), .rd_val_o(t_rd_val), .rd_rdy_i(t_rd_rdy),
        .rd_msg_o(t_rd_msg), .count_o(t_count), .full_o(t_full), .overflow_o(t_ovf),
        .cycles_o(t_cycles));

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        a_reset = 1'b0; a_en = 1'b1; a_clear = 1'b0; a_rd_rdy = 1'b0; a_val = '0; a_rdy = '0;
        w_reset = 1'b0; w_en = 1'b0; w_clear = 1'b0; w_rd_rdy = 1'b0; w_val = '0; w_rdy = '0;
        t_reset = 1'b0; t_en = 1'b0; t_clear = 1'b0; t_rd_rdy = 1'b0; t_val = '0; t_rdy = '0;

        // Reset held with live monitor activity.
        for (int i = 0; i < 3; i++) begin
            a_val = 4'(i);
            a_rdy = ~4'(i);
            applyStimulus();
        end
        checkOutput("rst_rd_val", 32'(a_rd_val), 32'd0);
        checkOutput("rst_rd_msg", 32'(a_rd_msg), 32'd0);
        checkOutput("rst_count", 32'(a_count), 32'd0);
        checkOutput("rst_full", 32'(a_full), 32'd0);
        checkOutput("rst_ovf", 32'(a_ovf), 32'd0);
        checkOutput("rst_cycles", 32'(a_cycles), 32'd0);

        a_reset = 1'b1;
        a_val = 4'b0000;
        a_rdy = 4'b1010;
        applyStimulus();
        checkOutput("first_rd_val", 32'(a_rd_val), 32'd1);
        checkOutput("first_msg", 32'(a_rd_msg), 32'h00000A);
        checkOutput("first_cycles", 32'(a_cycles), 32'd1);

        // Constant sample produces no further entries; a change at cycle 6 does.
        repeat (5) applyStimulus();
        checkOutput("cmp_count_const", 32'(a_count), 32'd1);
        a_val = 4'b0100;
        applyStimulus();
        checkOutput("cmp_count_chg", 32'(a_count), 32'd2);
        checkOutput("cmp_head0", 32'(a_rd_msg), 32'h00000A);
        a_rd_rdy = 1'b1;
        applyStimulus();
        checkOutput("cmp_head1", 32'(a_rd_msg), 32'h00064A);
        checkOutput("cmp_count_pop", 32'(a_count), 32'd1);
        applyStimulus();
        checkOutput("cmp_empty_val", 32'(a_rd_val), 32'd0);
        checkOutput("cmp_empty_msg", 32'(a_rd_msg), 32'd0);
        a_rd_rdy = 1'b0;

        // Clear with three entries pending.
        for (int i = 0; i < 3; i++) begin
            a_rdy = 4'(i + 1);
            applyStimulus();
        end
        checkOutput("clr_pre_count", 32'(a_count), 32'd3);
        a_clear = 1'b1;
        applyStimulus();
        checkOutput("clr_count", 32'(a_count), 32'd0);
        checkOutput("clr_ovf", 32'(a_ovf), 32'd0);
        checkOutput("clr_cycles", 32'(a_cycles), 32'd0);
        checkOutput("clr_rd_val", 32'(a_rd_val), 32'd0);
        a_clear = 1'b0;
        applyStimulus();
        checkOutput("clr_next_count", 32'(a_count), 32'd1);
        checkOutput("clr_next_msg", 32'(a_rd_msg), 32'h000043);

        // Six back-to-back events into four-entry buffers.
        w_reset = 1'b1;
        w_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w_rdy = 4'(i);
            applyStimulus();
        end
        checkOutput("wrap_count", 32'(w_count), 32'd4);
        checkOutput("wrap_full", 32'(w_full), 32'd1);
        checkOutput("wrap_ovf", 32'(w_ovf), 32'd1);
        checkOutput("stop_count", 32'(s_count), 32'd4);
        checkOutput("stop_full", 32'(s_full), 32'd1);
        checkOutput("stop_ovf", 32'(s_ovf), 32'd1);
        w_en = 1'b0;
        w_rd_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("wrap_drain", 32'(w_rd_msg), 32'({16'(k + 2), 4'b0000, 4'(k + 2)}));
            checkOutput("stop_drain", 32'(s_rd_msg), 32'({16'(k), 4'b0000, 4'(k)}));
            applyStimulus();
        end
        checkOutput("wrap_drained_val", 32'(w_rd_val), 32'd0);
        checkOutput("stop_drained_val", 32'(s_rd_val), 32'd0);
        checkOutput("stop_ovf_sticky", 32'(s_ovf), 32'd1);
        w_rd_rdy = 1'b0;

        w_clear = 1'b1;
        applyStimulus();
        w_clear = 1'b0;
        checkOutput("wrap_clr_ovf", 32'(w_ovf), 32'd0);
        checkOutput("stop_clr_cycles", 32'(s_cycles), 32'd0);

        // Full buffer with an event and a pop in the same cycle.
        w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_rdy = 4'(i);
            applyStimulus();
        end
        checkOutput("fp_full", 32'(w_full), 32'd1);
        checkOutput("fp_ovf_pre", 32'(w_ovf), 32'd0);
        w_rdy = 4'd4;
        w_rd_rdy = 1'b1;
        applyStimulus();
        checkOutput("fp_count", 32'(w_count), 32'd4);
        checkOutput("fp_ovf", 32'(w_ovf), 32'd0);
        checkOutput("fp_cycles", 32'(w_cycles), 32'd5);
        w_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("fp_drain", 32'(w_rd_msg), 32'({16'(k + 1), 4'b0000, 4'(k + 1)}));
            applyStimulus();
        end
        checkOutput("fp_drained_count", 32'(w_count), 32'd0);
        w_rd_rdy = 1'b0;

        // 4-bit timestamp: cycle 17 records as ts 1.
        t_reset = 1'b1;
        repeat (16) applyStimulus();
        checkOutput("ts_wrap_cycles", 32'(t_cycles), 32'd0);
        applyStimulus();
        checkOutput("ts_cycles17", 32'(t_cycles), 32'd1);
        t_en = 1'b1;
        t_val = 4'b0011;
        t_rdy = 4'b0101;
        applyStimulus();
        checkOutput("ts_count", 32'(t_count), 32'd1);
        checkOutput("ts_msg", 32'(t_rd_msg), 32'h135);
        checkOutput("ts_rd_val", 32'(t_rd_val), 32'd1);
        checkOutput("ts_full", 32'(t_full), 32'd0);
        checkOutput("ts_ovf", 32'(t_ovf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
